// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold the operand width itself (it counts w down to 1).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sub_stage.sv
// Combinational trial subtract for one restoring-division step:
// (b+1)-bit trial value minus the zero-extended divisor, with borrow out.
module sub_stage #(
  parameter int b = 8
) (
  input  logic [b:0]   trial,
  input  logic [b-1:0] dvs,
  output logic [b:0]   diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, trial} - {2'b00, dvs};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes in one cycle and raises div_zero.
module seq_divider
  import div_pkg::*;
#(
  parameter int b = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [b-1:0] x,
  input  logic [b-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [b-1:0] q,
  output logic [b-1:0] r,
  output logic         div_zero
);

  localparam int CW = cnt_width(b);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [b-1:0]  qd;
  logic [b-1:0]  rem;
  logic [b-1:0]  dvs;
  logic [b:0]    trial;
  logic [b:0]    diff;
  logic          borrow;
  logic          accept;
  logic          last;
  logic          zero_fast;
  logic          unused_diff_msb;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(1));
  assign trial  = {rem, qd[b-1]};

  sub_stage #(.b(b)) u_sub (
    .trial  (trial),
    .dvs    (dvs),
    .diff   (diff),
    .borrow (borrow)
  );

  // Without a borrow the difference is below the divisor, so its MSB is always zero.
  assign unused_diff_msb = diff[b];

`ifdef DIV_ZERO_DETECT_EN
  logic dz;

  assign zero_fast = (y == '0);
  assign div_zero  = dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz <= 1'b0;
    end else if (accept) begin
      dz <= zero_fast;
    end
  end
`else
  assign zero_fast = 1'b0;
  assign div_zero  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = zero_fast ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (accept) state_nx = zero_fast ? DONE : RUN;
               else state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // qd starts as the dividend and shifts quotient bits in at the LSB as dividend bits leave the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qd  <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (accept) begin
      dvs <= y;
      cnt <= CW'(b);
      if (zero_fast) begin
        qd  <= '1;
        rem <= x;
      end else begin
        qd  <= x;
        rem <= '0;
      end
    end else if (state == RUN) begin
      rem <= borrow ? trial[b-1:0] : diff[b-1:0];
      qd  <= {qd[b-2:0], ~borrow};
      cnt <= cnt - CW'(1);
    end
  end

  assign q = qd;
  assign r = rem;

endmodule
